// File: rtl/sprite_pkg.sv
// Shared types, default parameters and helpers for the sprite compositor.
package sprite_pkg;

    localparam int DEF_NUM_LAYERS   = 8;
    localparam int DEF_IDX_W        = 4;
    localparam int DEF_BANK_W       = 2;
    localparam int DEF_COLOR_W      = 8;
    localparam int DEF_TRANSP_IDX   = 15;
    localparam int DEF_FLASH_FRAMES = 16;

    localparam int LAYER_W = $clog2(DEF_NUM_LAYERS);

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    typedef logic [DEF_BANK_W+DEF_IDX_W-1:0] pal_addr_t;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_compositor_prio.sv
// Priority encoder: picks the highest-numbered opaque layer.
module layer_priority_enc
    import sprite_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int WIN_W      = $clog2(DEF_NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0] opaque,
    output logic                  hit,
    output logic [WIN_W-1:0]      winner
);

    // Scan upward so the last (highest) opaque layer overwrites lower ones.
    always_comb begin
        hit    = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (opaque[i]) begin
                hit    = 1'b1;
                winner = WIN_W'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Layer compositor: opaque test, priority resolve and multi-bank palette
// lookup with frame-synchronous palette flashing. Fixed latency of 3.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_LAYERS   = DEF_NUM_LAYERS,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int BANK_W       = DEF_BANK_W,
    parameter int COLOR_W      = DEF_COLOR_W,
    parameter int TRANSP_IDX   = DEF_TRANSP_IDX,
    parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           pix_valid_in,
    input  logic                           blank_in,
    input  logic                           frame_start,
    input  logic [NUM_LAYERS-1:0]          layer_en,
    input  logic [NUM_LAYERS*IDX_W-1:0]    layer_idx,
    input  logic [NUM_LAYERS*BANK_W-1:0]   layer_bank,
    input  logic [NUM_LAYERS-1:0]          layer_flash,
    input  logic                           pal_we,
    input  logic [BANK_W+IDX_W-1:0]        pal_waddr,
    input  logic [3*COLOR_W-1:0]           pal_wdata,
    output logic [COLOR_W-1:0]             VGA_R,
    output logic [COLOR_W-1:0]             VGA_G,
    output logic [COLOR_W-1:0]             VGA_B,
    output logic                           pix_valid_out,
    output logic                           hit_any,
    output logic [$clog2(NUM_LAYERS)-1:0]  hit_layer
);

    localparam int HIT_W     = $clog2(NUM_LAYERS);
    localparam int ADDR_W    = BANK_W + IDX_W;
    localparam int PAL_DEPTH = 1 << ADDR_W;
    localparam int RGB_W     = 3 * COLOR_W;
    localparam int FC_W      = clog2_min1(FLASH_FRAMES);

    logic [FC_W-1:0]              flash_cnt;
    logic                         flash_phase;

    logic [RGB_W-1:0]             pal_mem [PAL_DEPTH];

    logic [NUM_LAYERS-1:0]        opaque_d;
    logic [NUM_LAYERS*BANK_W-1:0] bank_d;

    logic [NUM_LAYERS-1:0]        s1_opaque;
    logic [NUM_LAYERS*BANK_W-1:0] s1_bank;
    logic [NUM_LAYERS*IDX_W-1:0]  s1_idx;
    logic                         s1_valid;
    logic                         s1_active;

    logic                         enc_hit;
    logic [HIT_W-1:0]             enc_win;
    logic [ADDR_W-1:0]            s2_addr_d;

    logic [ADDR_W-1:0]            s2_addr;
    logic                         s2_hit;
    logic [HIT_W-1:0]             s2_layer;
    logic                         s2_valid;
    logic                         s2_active;

    logic [RGB_W-1:0]             rgb_q;

    // Frame counter; the phase flips every FLASH_FRAMES frame pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else if (frame_start) begin
            if (flash_cnt == FC_W'(FLASH_FRAMES - 1)) begin
                flash_cnt   <= '0;
                flash_phase <= ~flash_phase;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end
    end

    // Palette storage; a read on the write edge still sees the old entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                pal_mem[i] <= '0;
            end
        end else if (pal_we) begin
            pal_mem[pal_waddr] <= pal_wdata;
        end
    end

    // Per-layer opaque test and flash-adjusted bank from the raw inputs.
    always_comb begin
        opaque_d = '0;
        bank_d   = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            opaque_d[i] = layer_en[i] &&
                          (layer_idx[i*IDX_W +: IDX_W] != IDX_W'(TRANSP_IDX));
            bank_d[i*BANK_W +: BANK_W] = layer_bank[i*BANK_W +: BANK_W] ^
                                         BANK_W'(flash_phase & layer_flash[i]);
        end
    end

    // Stage 1: capture the pixel slot.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_opaque <= '0;
            s1_bank   <= '0;
            s1_idx    <= '0;
            s1_valid  <= 1'b0;
            s1_active <= 1'b0;
        end else begin
            s1_opaque <= opaque_d;
            s1_bank   <= bank_d;
            s1_idx    <= layer_idx;
            s1_valid  <= pix_valid_in;
            s1_active <= pix_valid_in & ~blank_in;
        end
    end

    layer_priority_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .WIN_W      (HIT_W)
    ) u_prio (
        .opaque (s1_opaque),
        .hit    (enc_hit),
        .winner (enc_win)
    );

    // Palette address of the winner, or the bank-0 transparent entry as background.
    always_comb begin
        s2_addr_d = {BANK_W'(0), IDX_W'(TRANSP_IDX)};
        if (enc_hit) begin
            s2_addr_d = {s1_bank[int'(enc_win)*BANK_W +: BANK_W],
                         s1_idx[int'(enc_win)*IDX_W +: IDX_W]};
        end
    end

    // Stage 2: register the resolved winner and palette address.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_addr   <= '0;
            s2_hit    <= 1'b0;
            s2_layer  <= '0;
            s2_valid  <= 1'b0;
            s2_active <= 1'b0;
        end else begin
            s2_addr   <= s2_addr_d;
            s2_hit    <= s1_active & enc_hit;
            s2_layer  <= (s1_active && enc_hit) ? enc_win : '0;
            s2_valid  <= s1_valid;
            s2_active <= s1_active;
        end
    end

    // Stage 3: palette read into the output register; inactive slots are black.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q         <= '0;
            hit_any       <= 1'b0;
            hit_layer     <= '0;
            pix_valid_out <= 1'b0;
        end else begin
            rgb_q         <= s2_active ? pal_mem[s2_addr] : '0;
            hit_any       <= s2_hit;
            hit_layer     <= s2_layer;
            pix_valid_out <= s2_valid;
        end
    end

    assign VGA_R = rgb_q[RGB_W-1 -: COLOR_W];
    assign VGA_G = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor (FLASH_FRAMES = 2).
module tb_sprite_compositor;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid_in;
    logic        blank_in;
    logic        frame_start;
    logic [7:0]  layer_en;
    logic [31:0] layer_idx;
    logic [15:0] layer_bank;
    logic [7:0]  layer_flash;
    logic        pal_we;
    logic [5:0]  pal_waddr;
    logic [23:0] pal_wdata;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        pix_valid_out;
    logic        hit_any;
    logic [2:0]  hit_layer;

    int checks = 0;
    int errors = 0;

    sprite_compositor #(
        .NUM_LAYERS   (8),
        .IDX_W        (4),
        .BANK_W       (2),
        .COLOR_W      (8),
        .TRANSP_IDX   (15),
        .FLASH_FRAMES (2)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .pix_valid_in  (pix_valid_in),
        .blank_in      (blank_in),
        .frame_start   (frame_start),
        .layer_en      (layer_en),
        .layer_idx     (layer_idx),
        .layer_bank    (layer_bank),
        .layer_flash   (layer_flash),
        .pal_we        (pal_we),
        .pal_waddr     (pal_waddr),
        .pal_wdata     (pal_wdata),
        .VGA_R         (VGA_R),
        .VGA_G         (VGA_G),
        .VGA_B         (VGA_B),
        .pix_valid_out (pix_valid_out),
        .hit_any       (hit_any),
        .hit_layer     (hit_layer)
    );

    always #5 Clk = ~Clk;

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic pal_write(input logic [5:0] addr, input logic [23:0] data);
        @(negedge Clk);
        pal_we    = 1'b1;
        pal_waddr = addr;
        pal_wdata = data;
        @(negedge Clk);
        pal_we    = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    // All layers transparent/disabled, bank 0, no flashing.
    task automatic clear_layers();
        layer_en    = 8'h00;
        layer_idx   = {8{4'hF}};
        layer_bank  = 16'h0000;
        layer_flash = 8'h00;
    endtask

    task automatic test_reset();
        Reset_n      = 1'b0;
        pix_valid_in = 1'b0;
        blank_in     = 1'b0;
        frame_start  = 1'b0;
        pal_we       = 1'b0;
        pal_waddr    = '0;
        pal_wdata    = '0;
        clear_layers();
        wait_neg(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, pix_valid_out, hit_any, hit_layer} !== 29'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h exp 0",
                     {VGA_R, VGA_G, VGA_B, pix_valid_out, hit_any, hit_layer});
        end
        Reset_n = 1'b1;
        pal_write({2'd0, 4'd15}, 24'h000000);
        pal_write({2'd0, 4'd7},  24'hFFFF21);
        pal_write({2'd0, 4'd1},  24'hDE0000);
    endtask

    task automatic test_single_layer();
        @(negedge Clk);
        clear_layers();
        layer_en          = 8'h08;
        layer_idx[12 +: 4] = 4'd7;
        pix_valid_in      = 1'b1;
        wait_neg(2);
        checks++;
        if (pix_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_early got %b exp 0", pix_valid_out);
        end
        wait_neg(1);
        checks++;
        if ({pix_valid_out, VGA_R, VGA_G, VGA_B, hit_any, hit_layer} !== {1'b1, 24'hFFFF21, 1'b1, 3'd3}) begin
            errors++;
            $display("[TB] FAIL single_layer got v=%b rgb=%h hit=%b l=%0d exp v=1 rgb=ffff21 hit=1 l=3",
                     pix_valid_out, {VGA_R, VGA_G, VGA_B}, hit_any, hit_layer);
        end
    endtask

    task automatic test_priority();
        @(negedge Clk);
        clear_layers();
        layer_en           = 8'h24;
        layer_idx[8 +: 4]  = 4'd1;
        layer_idx[20 +: 4] = 4'd7;
        wait_neg(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, hit_any, hit_layer} !== {24'hFFFF21, 1'b1, 3'd5}) begin
            errors++;
            $display("[TB] FAIL priority_top got rgb=%h hit=%b l=%0d exp rgb=ffff21 hit=1 l=5",
                     {VGA_R, VGA_G, VGA_B}, hit_any, hit_layer);
        end
        layer_en = 8'h04;
        wait_neg(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, hit_any, hit_layer} !== {24'hDE0000, 1'b1, 3'd2}) begin
            errors++;
            $display("[TB] FAIL priority_lower got rgb=%h hit=%b l=%0d exp rgb=de0000 hit=1 l=2",
                     {VGA_R, VGA_G, VGA_B}, hit_any, hit_layer);
        end
    endtask

    task automatic test_background();
        pal_write({2'd0, 4'd15}, 24'h2121FF);
        clear_layers();
        wait_neg(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, hit_any, hit_layer} !== {24'h2121FF, 1'b0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL background_disabled got rgb=%h hit=%b l=%0d exp rgb=2121ff hit=0 l=0",
                     {VGA_R, VGA_G, VGA_B}, hit_any, hit_layer);
        end
        layer_en   = 8'hFF;
        layer_bank = 16'hFFFF;
        wait_neg(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, hit_any, hit_layer} !== {24'h2121FF, 1'b0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL background_transp got rgb=%h hit=%b l=%0d exp rgb=2121ff hit=0 l=0",
                     {VGA_R, VGA_G, VGA_B}, hit_any, hit_layer);
        end
    endtask

    task automatic test_blank();
        @(negedge Clk);
        clear_layers();
        layer_en           = 8'h08;
        layer_idx[12 +: 4] = 4'd7;
        blank_in           = 1'b1;
        wait_neg(3);
        checks++;
        if ({pix_valid_out, VGA_R, VGA_G, VGA_B, hit_any, hit_layer} !== {1'b1, 24'h0, 1'b0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL blank got v=%b rgb=%h hit=%b l=%0d exp v=1 rgb=000000 hit=0 l=0",
                     pix_valid_out, {VGA_R, VGA_G, VGA_B}, hit_any, hit_layer);
        end
        blank_in     = 1'b0;
        pix_valid_in = 1'b0;
        wait_neg(3);
        checks++;
        if ({pix_valid_out, VGA_R, VGA_G, VGA_B, hit_any, hit_layer} !== 29'd0) begin
            errors++;
            $display("[TB] FAIL invalid_slot got v=%b rgb=%h hit=%b l=%0d exp all 0",
                     pix_valid_out, {VGA_R, VGA_G, VGA_B}, hit_any, hit_layer);
        end
        pix_valid_in = 1'b1;
    endtask

    task automatic test_flash();
        pal_write({2'd2, 4'd4}, 24'h2121FF);
        pal_write({2'd3, 4'd4}, 24'hFFB5FF);
        clear_layers();
        layer_en          = 8'h02;
        layer_idx[4 +: 4] = 4'd4;
        layer_bank[2 +: 2] = 2'd2;
        layer_flash       = 8'h02;
        wait_neg(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, hit_layer} !== {24'h2121FF, 3'd1}) begin
            errors++;
            $display("[TB] FAIL flash_phase0 got rgb=%h l=%0d exp rgb=2121ff l=1",
                     {VGA_R, VGA_G, VGA_B}, hit_layer);
        end
        pulse_frame();
        wait_neg(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h2121FF) begin
            errors++;
            $display("[TB] FAIL flash_one_pulse got %h exp 2121ff", {VGA_R, VGA_G, VGA_B});
        end
        pulse_frame();
        wait_neg(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'hFFB5FF) begin
            errors++;
            $display("[TB] FAIL flash_phase1 got %h exp ffb5ff", {VGA_R, VGA_G, VGA_B});
        end
        layer_flash = 8'h00;
        wait_neg(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h2121FF) begin
            errors++;
            $display("[TB] FAIL flash_disabled_layer got %h exp 2121ff", {VGA_R, VGA_G, VGA_B});
        end
        layer_flash = 8'h02;
        pulse_frame();
        pulse_frame();
        wait_neg(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h2121FF) begin
            errors++;
            $display("[TB] FAIL flash_back_phase0 got %h exp 2121ff", {VGA_R, VGA_G, VGA_B});
        end
    endtask

    task automatic test_collision();
        @(negedge Clk);
        clear_layers();
        layer_en           = 8'h08;
        layer_idx[12 +: 4] = 4'd7;
        wait_neg(3);
        pal_we    = 1'b1;
        pal_waddr = {2'd0, 4'd7};
        pal_wdata = 24'h123456;
        @(negedge Clk);
        pal_we = 1'b0;
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFF21) begin
            errors++;
            $display("[TB] FAIL collision_old got %h exp ffff21", {VGA_R, VGA_G, VGA_B});
        end
        @(negedge Clk);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h123456) begin
            errors++;
            $display("[TB] FAIL collision_new got %h exp 123456", {VGA_R, VGA_G, VGA_B});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge Clk);
        clear_layers();
        layer_en           = 8'h08;
        layer_idx[12 +: 4] = 4'd7;
        layer_idx[8 +: 4]  = 4'd1;
        @(negedge Clk);
        layer_en = 8'h04;
        @(negedge Clk);
        pix_valid_in = 1'b0;
        @(negedge Clk);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, hit_layer} !== {24'h123456, 3'd3}) begin
            errors++;
            $display("[TB] FAIL b2b_first got rgb=%h l=%0d exp rgb=123456 l=3",
                     {VGA_R, VGA_G, VGA_B}, hit_layer);
        end
        @(negedge Clk);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, hit_layer} !== {24'hDE0000, 3'd2}) begin
            errors++;
            $display("[TB] FAIL b2b_second got rgb=%h l=%0d exp rgb=de0000 l=2",
                     {VGA_R, VGA_G, VGA_B}, hit_layer);
        end
        @(negedge Clk);
        checks++;
        if (pix_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end_valid got %b exp 0", pix_valid_out);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge Clk);
        clear_layers();
        layer_en           = 8'h08;
        layer_idx[12 +: 4] = 4'd7;
        pix_valid_in       = 1'b1;
        wait_neg(3);
        checks++;
        if ({pix_valid_out, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h123456}) begin
            errors++;
            $display("[TB] FAIL pre_reset got v=%b rgb=%h exp v=1 rgb=123456",
                     pix_valid_out, {VGA_R, VGA_G, VGA_B});
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({VGA_R, VGA_G, VGA_B, pix_valid_out, hit_any, hit_layer} !== 29'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got %h exp 0",
                     {VGA_R, VGA_G, VGA_B, pix_valid_out, hit_any, hit_layer});
        end
        pix_valid_in = 1'b0;
        wait_neg(2);
        Reset_n = 1'b1;
        @(negedge Clk);
        pix_valid_in = 1'b1;
        wait_neg(2);
        checks++;
        if (pix_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_early got %b exp 0", pix_valid_out);
        end
        @(negedge Clk);
        checks++;
        if ({pix_valid_out, VGA_R, VGA_G, VGA_B, hit_any, hit_layer} !== {1'b1, 24'h0, 1'b1, 3'd3}) begin
            errors++;
            $display("[TB] FAIL post_reset_pal_cleared got v=%b rgb=%h hit=%b l=%0d exp v=1 rgb=000000 hit=1 l=3",
                     pix_valid_out, {VGA_R, VGA_G, VGA_B}, hit_any, hit_layer);
        end
    endtask

    initial begin
        test_reset();
        test_single_layer();
        test_priority();
        test_background();
        test_blank();
        test_flash();
        test_collision();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised, pipelined successor to the per-pixel colour mapper.
- Each pixel, up to NUM_LAYERS sprite/tile layers each present a palette index. The block picks the highest-priority opaque layer and looks its colour up in a run-time writable multi-bank palette.
- Supports per-layer frame-synchronous palette flashing (frightened-ghost style).
- Sits between the per-layer sprite fetch units and the VGA DAC; registered RGB out, fixed latency 3.

Parameters:
- NUM_LAYERS, 8, number of layers; layer NUM_LAYERS-1 has top priority, layer 0 lowest.
- IDX_W, 4, palette index width per layer.
- BANK_W, 2, palette bank select width (2**BANK_W banks).
- COLOR_W, 8, bits per colour channel.
- TRANSP_IDX, 15, index value treated as transparent in every bank.
- FLASH_FRAMES, 16, frames per flash half-period; must be >= 1.

Ports:
- Clk  in  1  system clock (pixel clock domain).
- Reset_n  in  1  asynchronous, active-low reset.
- pix_valid_in  in  1  the current pixel slot carries an active-area pixel.
- blank_in  in  1  force black for this pixel.
- frame_start  in  1  one-cycle pulse at start of frame.
- layer_en  in  NUM_LAYERS  per-layer enable; a disabled layer is treated as transparent.
- layer_idx  in  NUM_LAYERS*IDX_W  per-layer palette index; layer i occupies bits [i*IDX_W +: IDX_W].
- layer_bank  in  NUM_LAYERS*BANK_W  per-layer bank select, packed the same way.
- layer_flash  in  NUM_LAYERS  layer participates in flashing.
- pal_we  in  1  palette write strobe.
- pal_waddr  in  BANK_W+IDX_W  write address, {bank, index}.
- pal_wdata  in  3*COLOR_W  write data, {R, G, B}.
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  pixel colour.
- pix_valid_out  out  1  pix_valid_in delayed by 3.
- hit_any  out  1  an opaque layer won this pixel.
- hit_layer  out  $clog2(NUM_LAYERS)  winning layer number; 0 when hit_any=0.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - All outputs 0; all pipeline registers 0.
  - Flash counter 0; flash_phase 0.
  - All palette entries reset to 0.
- Pipeline: inputs sampled at edge k (S1); priority resolve at edge k+1 (S2); palette read and output register at edge k+2. Outputs reflect the edge-k inputs after edge k+2. One pixel per clock, no stalls.
- Opaque test: layer i is opaque iff layer_en[i]=1 and layer_idx_i != TRANSP_IDX.
- Priority: the highest-numbered opaque layer wins. If no layer is opaque, the background colour is palette[{0, TRANSP_IDX}] and hit_any=0.
- Effective bank: layer_bank_i XOR {(BANK_W-1)'b0, flash_phase & layer_flash[i]}, i.e. flashing toggles the bank LSB.
- Flash timer:
  - On frame_start, the counter increments.
  - When the counter equals FLASH_FRAMES-1 and frame_start is high, the counter wraps to 0 and flash_phase toggles.
  - A new flash_phase applies to pixels sampled at S1 on the edge after the update edge.
- blank_in=1 or pix_valid_in=0 at S1: that slot outputs RGB=0, hit_any=0, hit_layer=0. pix_valid_out still follows pix_valid_in.
- Palette:
  - 2**(BANK_W+IDX_W) entries of 3*COLOR_W bits; synchronous write at the edge with pal_we=1.
  - Simultaneous write and read of the same entry at the same edge returns the old value; the new value is seen by the pixel read on the next edge.
  - Writes are allowed at any time, including mid-frame.
- Reset mid-frame: the pipeline flushes immediately. The first valid output appears 3 edges after the first sampled pixel following reset release.
- Width rules: all index compares are IDX_W bits; no arithmetic overflow paths other than the flash counter wrap.

Decomposition:
- Package sprite_pkg: rgb_t struct {R, G, B} of COLOR_W each; pal_addr_t; localparam LAYER_W = $clog2(NUM_LAYERS); shared TRANSP_IDX default.
- One sub-module: layer_priority_enc (combinational; opaque vector to winner number plus hit). Palette and flash timer stay in the top module.

Test Plan:
- Reset, then write palette[{0,15}]=0x000000 and [{0,7}]=0xFFFF21. Drive layer 3 en, idx 7, all others idx 15, pix_valid_in=1 -> after 3 edges RGB=FF,FF,21; hit_any=1; hit_layer=3.
- Priority: layer 2 idx 1 (palette 0xDE0000) and layer 5 idx 7, both enabled -> hit_layer=5, RGB=FFFF21. Disable layer 5 -> next pixel gives hit_layer=2, RGB=DE0000.
- All layers transparent or disabled, with palette[{0,15}] written 0x2121FF -> RGB=21,21,FF; hit_any=0; hit_layer=0.
- Flash, FLASH_FRAMES=2: layer 1 flash=1, bank 2, idx 4; palette[{2,4}]=0x2121FF and [{3,4}]=0xFFB5FF. Pulse frame_start twice -> colour switches from 2121FF to FFB5FF; two more pulses -> back to 2121FF. A layer with flash=0 stays constant.
- Write/read collision: pal_we to {0,7}=0x123456 on the same edge the pixel using {0,7} is read -> old colour output; the next pixel gets 0x123456.
- Assert Reset_n low mid-stream with pix_valid_in=1 -> all outputs 0 immediately and palette cleared. After release, pix_valid_out rises exactly 3 edges after the first valid sample.
